// File: rtl/mipi_csi_rx_raw10_depacker_2lane.sv
// ---------------------------------------------------------------------------
// mipi_csi_rx_raw10_depacker_2lane
//   Unpacks the 16-bit RAW10 payload stream from the 2-lane CSI-2 packet
//   decoder into 10-bit pixels, four per output beat. Every 5 payload bytes
//   (B0..B4) form one group. B0..B3 carry the pixel MSBs and B4 carries the
//   four 2-bit LSB fields. The block also reports the per-line pixel count
//   and flags packets that end part-way through a group.
//
// Ports
//   clk_i          byte clock shared with the packet decoder
//   reset_i        asynchronous, active-low reset
//   data_valid_i   payload valid; high and contiguous for one packet
//   data_i[15:0]   payload bytes; [7:0] is the earlier byte on the wire
//   packet_type_i  decoder packet class, sampled on the first word
//   pixel_valid_o  pixel_o carries four new pixels
//   pixel_o[39:0]  {p3,p2,p1,p0}; p0 is the earliest pixel
//   line_done_o    1-cycle pulse at the end of each accepted RAW10 packet
//   line_pixels_o  pixel count of the last completed line (saturating)
//   truncated_o    pulses with line_done_o when 1-4 leftover bytes remain
// ---------------------------------------------------------------------------

// Single-pixel unpack: 8 MSBs from the pixel's own byte, 2 LSBs from B4.
module raw10_pix_unpack (
  input  logic [7:0] msb_i,
  input  logic [1:0] lsb_i,
  output logic [9:0] pix_o
);
  assign pix_o = {msb_i, lsb_i};
endmodule

module mipi_csi_rx_raw10_depacker_2lane #(
  parameter logic [2:0]  RAW10_TYPE      = 3'd2,
  parameter logic [15:0] MAX_LINE_PIXELS = 16'd4096
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        data_valid_i,
  input  logic [15:0] data_i,
  input  logic [2:0]  packet_type_i,
  output logic        pixel_valid_o,
  output logic [39:0] pixel_o,
  output logic        line_done_o,
  output logic [15:0] line_pixels_o,
  output logic        truncated_o
);

  localparam int NUM_PIX = 4;
  localparam int PIX_W   = 10;

  typedef enum logic [1:0] {IDLE, ACTIVE, SKIP} state_t;

  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic [47:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [39:0] pixel_q, pixel_d;
  logic        line_done_q, line_done_d;
  logic [15:0] line_pixels_q, line_pixels_d;
  logic        truncated_q, truncated_d;

  logic        take_word;
  logic [47:0] acc_merged;
  logic [2:0]  cnt_sum;
  logic        group_rdy;
  logic [16:0] pix_sum;
  logic [NUM_PIX-1:0][PIX_W-1:0] grp_pix;

  // Bytes are held LSB-first, so the new word lands just above the held
  // bytes. Bytes above cnt_q are always zero, which makes OR-merging safe.
  assign acc_merged = acc_q | ({32'd0, data_i} << {cnt_q, 3'b000});
  assign cnt_sum    = cnt_q + 3'd2;
  assign group_rdy  = (cnt_sum >= 3'd5);
  assign pix_sum    = {1'b0, pix_cnt_q} + 17'd4;

  genvar g;
  generate
    for (g = 0; g < NUM_PIX; g++) begin : g_pix
      raw10_pix_unpack u_unpack (
        .msb_i (acc_merged[8*g +: 8]),
        .lsb_i (acc_merged[32 + 2*g +: 2]),
        .pix_o (grp_pix[g])
      );
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    // After reset, a packet already in flight is ignored until the valid
    // line has been observed low.
    armed_d       = armed_q | ~data_valid_i;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    pix_cnt_d     = pix_cnt_q;
    pixel_valid_d = 1'b0;
    pixel_d       = pixel_q;
    line_done_d   = 1'b0;
    line_pixels_d = line_pixels_q;
    truncated_d   = 1'b0;
    take_word     = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_valid_i && armed_q) begin
          if (packet_type_i == RAW10_TYPE) begin
            state_d   = ACTIVE;
            take_word = 1'b1;
          end else begin
            state_d = SKIP;
          end
        end
      end
      ACTIVE: begin
        if (data_valid_i) begin
          take_word = 1'b1;
        end else begin
          // End of line: report, then drop any partial group.
          state_d       = IDLE;
          line_done_d   = 1'b1;
          line_pixels_d = pix_cnt_q;
          truncated_d   = (cnt_q != 3'd0);
          acc_d         = '0;
          cnt_d         = '0;
          pix_cnt_d     = '0;
        end
      end
      SKIP: begin
        if (!data_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (take_word) begin
      if (group_rdy) begin
        pixel_valid_d = 1'b1;
        pixel_d       = grp_pix;
        acc_d         = {40'd0, acc_merged[47:40]};
        cnt_d         = cnt_sum - 3'd5;
        pix_cnt_d     = (pix_sum > {1'b0, MAX_LINE_PIXELS}) ? MAX_LINE_PIXELS
                                                            : pix_sum[15:0];
      end else begin
        acc_d = acc_merged;
        cnt_d = cnt_sum;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= IDLE;
      armed_q       <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      pix_cnt_q     <= '0;
      pixel_valid_q <= 1'b0;
      pixel_q       <= '0;
      line_done_q   <= 1'b0;
      line_pixels_q <= '0;
      truncated_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_q       <= pixel_d;
      line_done_q   <= line_done_d;
      line_pixels_q <= line_pixels_d;
      truncated_q   <= truncated_d;
    end
  end

  assign pixel_valid_o = pixel_valid_q;
  assign pixel_o       = pixel_q;
  assign line_done_o   = line_done_q;
  assign line_pixels_o = line_pixels_q;
  assign truncated_o   = truncated_q;

endmodule
